// File: rtl/inst_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_rom_loader
// Description : Instruction ROM with a streaming image loader. An image is
//               written word by word after load_start_i; the core is held in
//               reset until the last word arrives, after which fetches are
//               served combinationally from the loaded memory.
//               Optional feature macro: LOAD_CHECKSUM_EN (running sum of the
//               loaded image on checksum_o).
// Revision    : 1.0 - initial release
// ============================================================================
module inst_rom_loader #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  input  logic        load_start_i,
  input  logic        load_valid_i,
  input  logic [31:0] load_data_i,
  input  logic        load_last_i,
  output logic        load_ready_o,
  output logic        cpu_rst_o,
  output logic        load_err_o,
  output logic        addr_err_o,
  output logic [31:0] checksum_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2:0]   wr_cnt_q, wr_cnt_d;
  logic                  load_err_q, load_err_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic [31:0]           mem_q [0:(2**DEPTH_LOG2)-1];

  logic                  accept_w;
  logic                  full_w;
  logic                  wr_en_w;
  logic                  in_range_w;
  logic                  fetch_w;
  logic                  unused_w;

  // The write counter saturates at exactly 2**DEPTH_LOG2, so its MSB alone
  // flags a full memory.
  assign full_w   = wr_cnt_q[DEPTH_LOG2];
  // A start pulse wins over a word presented in the same cycle.
  assign accept_w = load_valid_i && load_ready_o && !load_start_i;
  assign wr_en_w  = accept_w && !full_w;

  assign load_ready_o = (state_q == LOAD) && !rst;
  assign cpu_rst_o    = cpu_rst_q;
  assign load_err_o   = load_err_q;

  // Fetch path: byte address, low two bits ignored, upper bits must be zero.
  assign in_range_w = (rom_addr_i[31:DEPTH_LOG2+2] == '0);
  assign fetch_w    = (state_q == RUN) && rom_ce_i && !rst;
  assign rom_data_o = (fetch_w && in_range_w) ? mem_q[rom_addr_i[DEPTH_LOG2+1:2]] : 32'h0;
  assign addr_err_o = fetch_w && !in_range_w;
  assign unused_w   = ^rom_addr_i[1:0];

  // Next-state, write counter, overflow flag and core-reset request.
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    load_err_d = load_err_q;
    case (state_q)
      IDLE:    if (load_start_i) state_d = LOAD;
      LOAD: begin
        if (load_start_i)               state_d = LOAD;
        else if (accept_w && load_last_i) state_d = RUN;
      end
      RUN:     if (load_start_i) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    if (load_start_i) begin
      wr_cnt_d   = '0;
      load_err_d = 1'b0;
    end else if (accept_w) begin
      if (full_w) load_err_d = 1'b1;
      else        wr_cnt_d   = wr_cnt_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
    end
    cpu_rst_d = (state_d != RUN);
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      load_err_q <= 1'b0;
      cpu_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      load_err_q <= load_err_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  // Image memory; never cleared so stale words survive resets and reloads.
  always_ff @(posedge clk) begin
    if (wr_en_w) mem_q[wr_cnt_q[DEPTH_LOG2-1:0]] <= load_data_i;
  end

`ifdef LOAD_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  // Running sum includes overflow words that were discarded from memory.
  always_comb begin
    checksum_d = checksum_q;
    if (load_start_i)  checksum_d = 32'h0;
    else if (accept_w) checksum_d = checksum_q + load_data_i;
  end

  // Checksum accumulator register.
  always_ff @(posedge clk) begin
    if (rst) checksum_q <= 32'h0;
    else     checksum_q <= checksum_d;
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_rom_loader
// Description : Self-checking bench for inst_rom_loader: directed scenarios
//               with literal expectations plus a randomized phase compared
//               every cycle against a behavioural image/loader model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_rom_loader;

  localparam int DL2   = 10;
  localparam int WORDS = 1 << DL2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        cpu_rst;
  logic        load_err;
  logic        addr_err;
  logic [31:0] checksum;

  int checks = 0;
  int passes = 0;

  inst_rom_loader #(.DEPTH_LOG2(DL2)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_i     (rom_ce),
    .rom_addr_i   (rom_addr),
    .rom_data_o   (rom_data),
    .load_start_i (load_start),
    .load_valid_i (load_valid),
    .load_data_i  (load_data),
    .load_last_i  (load_last),
    .load_ready_o (load_ready),
    .cpu_rst_o    (cpu_rst),
    .load_err_o   (load_err),
    .addr_err_o   (addr_err),
    .checksum_o   (checksum)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Mode: 0 idle, 1 loading, 2 running.
  int          m_mode = 0;
  int          m_cnt  = 0;
  bit          m_err  = 1'b0;
  bit          m_cpu  = 1'b1;
  logic [31:0] m_sum  = 32'h0;
  logic [31:0] m_mem [WORDS];
  bit          m_wr  [WORDS];
  bit          mdl_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0; m_cnt <= 0; m_err <= 1'b0; m_sum <= 32'h0; m_cpu <= 1'b1;
      mdl_ok <= 1'b1;
    end else if (load_start) begin
      m_mode <= 1; m_cnt <= 0; m_err <= 1'b0; m_sum <= 32'h0; m_cpu <= 1'b1;
    end else if (m_mode == 1 && load_valid) begin
      m_sum <= m_sum + load_data;
      if (m_cnt < WORDS) begin
        m_mem[m_cnt] <= load_data;
        m_wr[m_cnt]  <= 1'b1;
        m_cnt        <= m_cnt + 1;
      end else begin
        m_err <= 1'b1;
      end
      if (load_last) begin
        m_mode <= 2;
        m_cpu  <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    #2;
    if (mdl_ok) begin
      logic        run_fetch;
      logic        inr;
      int          idx;
      logic [31:0] exp_sum;
      run_fetch = !rst && (m_mode == 2) && rom_ce;
      inr       = ((rom_addr >> (DL2 + 2)) == 0);
      idx       = int'((rom_addr >> 2) & (WORDS - 1));
`ifdef LOAD_CHECKSUM_EN
      exp_sum = m_sum;
`else
      exp_sum = 32'h0;
`endif
      chk("mdl_ready",    {31'b0, load_ready}, {31'b0, (!rst && m_mode == 1)});
      chk("mdl_cpu_rst",  {31'b0, cpu_rst},    {31'b0, m_cpu});
      chk("mdl_load_err", {31'b0, load_err},   {31'b0, m_err});
      chk("mdl_addr_err", {31'b0, addr_err},   {31'b0, (run_fetch && !inr)});
      chk("mdl_checksum", checksum, exp_sum);
      if (run_fetch && inr) begin
        if (m_wr[idx]) chk("mdl_rom_data", rom_data, m_mem[idx]);
      end else begin
        chk("mdl_rom_data", rom_data, 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic s, input logic v, input logic [31:0] d,
                       input logic l, input logic c, input logic [31:0] a);
    @(negedge clk);
    load_start = s; load_valid = v; load_data = d; load_last = l;
    rom_ce = c; rom_addr = a;
  endtask

  initial begin
    logic [31:0] exp_ck;
    rst = 1'b1; load_start = 0; load_valid = 0; load_data = 0; load_last = 0;
    rom_ce = 1'b1; rom_addr = 32'h1000;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_cpu_rst",  {31'b0, cpu_rst},    32'd1);
    chk("rst_ready",    {31'b0, load_ready}, 32'd0);
    chk("rst_load_err", {31'b0, load_err},   32'd0);
    chk("rst_addr_err", {31'b0, addr_err},   32'd0);
    chk("rst_rom_data", rom_data, 32'h0);
    chk("rst_checksum", checksum, 32'h0);

    // Basic three-word image.
    @(negedge clk); rst = 1'b0; rom_ce = 1'b0; rom_addr = 0;
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'd11, 0, 0, 0);
    drive(0, 1, 32'd22, 0, 0, 0);
    drive(0, 1, 32'd33, 1, 0, 0); #3;
    chk("held_before_last", {31'b0, cpu_rst}, 32'd1);
    drive(0, 0, 0, 0, 1, 32'h0); #3;
    chk("cpu_rst_falls", {31'b0, cpu_rst}, 32'd0);
    chk("fetch_0", rom_data, 32'd11);
    drive(0, 0, 0, 0, 1, 32'h4); #3; chk("fetch_4", rom_data, 32'd22);
    drive(0, 0, 0, 0, 1, 32'h8); #3; chk("fetch_8", rom_data, 32'd33);
    drive(0, 0, 0, 0, 1, 32'h7); #3; chk("fetch_low_bits_ignored", rom_data, 32'd22);
    drive(0, 0, 0, 0, 0, 32'h4); #3; chk("ce_low_zero", rom_data, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h1000); #3;
    chk("oob_data", rom_data, 32'h0);
    chk("oob_addr_err", {31'b0, addr_err}, 32'd1);

    // Checksum wrap-around.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
    drive(0, 1, 32'h2, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0); #3;
`ifdef LOAD_CHECKSUM_EN
    exp_ck = 32'h1;
`else
    exp_ck = 32'h0;
`endif
    chk("checksum_wrap", checksum, exp_ck);

    // Start coincident with a valid word: word dropped, next one at index 0.
    drive(1, 1, 32'hDEAD, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0); #3;
    chk("restart_cpu_rst", {31'b0, cpu_rst},    32'd1);
    chk("restart_ready",   {31'b0, load_ready}, 32'd1);
    drive(0, 1, 32'h55, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h0); #3; chk("coincident_idx0", rom_data, 32'h55);
    drive(0, 0, 0, 0, 1, 32'h4); #3; chk("stale_idx1", rom_data, 32'h2);

    // Reset in the middle of a load.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h77, 0, 0, 0);
    drive(0, 1, 32'h88, 0, 0, 0);
    @(negedge clk); rst = 1'b1; #3;
    chk("rst_midload_ready", {31'b0, load_ready}, 32'd0);
    @(negedge clk); rst = 1'b0; load_valid = 1'b0; #3;
    chk("after_rst_ready",   {31'b0, load_ready}, 32'd0);
    chk("after_rst_cpu_rst", {31'b0, cpu_rst},    32'd1);

    // Overflow: one word more than the memory holds.
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i <= WORDS; i++) begin
      drive(0, 1, 32'h1000 + i, (i == WORDS), 0, 0);
      if (i == WORDS) begin
        #3; chk("no_err_at_full", {31'b0, load_err}, 32'd0);
      end
    end
    drive(0, 0, 0, 0, 1, 32'h0); #3;
    chk("overflow_err",     {31'b0, load_err}, 32'd1);
    chk("overflow_run",     {31'b0, cpu_rst},  32'd0);
    chk("overflow_word0",   rom_data, 32'h1000);
    drive(0, 0, 0, 0, 1, 32'hFFC); #3;
    chk("overflow_lastidx", rom_data, 32'h1000 + WORDS - 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) != 0) ? ($urandom & 32'hFFF) : $urandom;
      drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1, $urandom,
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7), a);
      rst = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    rst = 1'b0; load_start = 0; load_valid = 0;
    @(negedge clk); #5;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
